// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-stage front end for a 128x32 word-addressed data memory with a
// registered read port. Accepts byte-addressed byte/half/word loads and
// stores, rejects misaligned or reserved-size requests, performs sub-word
// stores as read-modify-write, and returns extended load data.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved
//   req_signed        loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address (little-endian lanes)
//   req_wdata         store data, right-aligned
//   ld_valid/ld_data  one-cycle pulse with the extended load result
//   err               one-cycle pulse for a rejected request
//   mem_*             data memory address/memWrite/memRead/writeData/readData
module load_store_unit #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              err,
    output logic [ADDR_W-3:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hFFFF);

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        RMW_MERGE
    } state_t;

    state_t state_q, state_d;

    // Request captured at acceptance; used by LD_WAIT and RMW_MERGE.
    logic [ADDR_W-3:0] sv_idx;
    logic [1:0]        sv_lane;
    logic [1:0]        sv_size;
    logic              sv_signed;
    logic [DATA_W-1:0] sv_wdata;

    logic              accept;
    logic              misaligned;
    logic [4:0]        shamt;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merge_mask;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_ext;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane offset in bits. An aligned half has lane bit 0 clear, so the same
    // shift serves byte and half lanes.
    assign shamt   = {sv_lane, 3'b000};
    assign ld_byte = 8'(mem_rdata >> shamt);
    assign ld_half = 16'(mem_rdata >> shamt);

    assign lane_mask  = (sv_size == SZ_BYTE) ? BYTE_MASK : HALF_MASK;
    assign merge_mask = lane_mask << shamt;
    assign merged     = (mem_rdata & ~merge_mask) | ((sv_wdata & lane_mask) << shamt);

    always_comb begin
        case (sv_size)
            SZ_BYTE: load_ext = sv_signed ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                          : {{(DATA_W-8){1'b0}}, ld_byte};
            SZ_HALF: load_ext = sv_signed ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                          : {{(DATA_W-16){1'b0}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next state and memory-side outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                // rst_n gates the decode so a request held during reset
                // never reaches the memory.
                if (rst_n && accept && !misaligned) begin
                    mem_address = req_addr[ADDR_W-1:2];
                    if (req_we && req_size == SZ_WORD) begin
                        mem_write = 1'b1;
                        mem_wdata = req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        mem_read = 1'b1;
                        state_d  = req_we ? RMW_MERGE : LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                state_d = IDLE;
            end
            RMW_MERGE: begin
                mem_write   = 1'b1;
                mem_address = sv_idx;
                mem_wdata   = merged;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            err       <= 1'b0;
            sv_idx    <= '0;
            sv_lane   <= '0;
            sv_size   <= '0;
            sv_signed <= 1'b0;
            sv_wdata  <= '0;
        end else begin
            state_q  <= state_d;
            ld_valid <= (state_q == LD_WAIT);
            err      <= accept && misaligned;
            if (state_q == LD_WAIT) begin
                ld_data <= load_ext;
            end
            if (accept && !misaligned) begin
                sv_idx    <= req_addr[ADDR_W-1:2];
                sv_lane   <= req_addr[1:0];
                sv_size   <= req_size;
                sv_signed <= req_signed;
                sv_wdata  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit. Hosts a 128x32 data memory with a
// registered read port and a byte-array reference model of memory contents.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err;
    logic [6:0]  mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .err         (err),
        .mem_address (mem_address),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Data memory: synchronous write, registered read, no reset.
    logic [31:0] mem [128];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_address];
    end

    // Reference: memory as 512 little-endian bytes.
    logic [7:0] ref_mem [512];

    function automatic logic [31:0] ref_word(input logic [8:0] a);
        int b;
        b = int'({a[8:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [1:0] sz, input logic sgn);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a);
        if (sz == 2'd0) begin
            b = ref_mem[i];
            return sgn ? {{24{b[7]}}, b} : {24'h0, b};
        end else if (sz == 2'd1) begin
            h = {ref_mem[i+1], ref_mem[i]};
            return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return ref_word(a);
    endfunction

    function automatic void ref_store(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] d);
        int i;
        i = int'(a);
        ref_mem[i] = d[7:0];
        if (sz != 2'd0) ref_mem[i+1] = d[15:8];
        if (sz == 2'd2) begin
            ref_mem[i+2] = d[23:16];
            ref_mem[i+3] = d[31:24];
        end
    endfunction

    function automatic logic is_misaligned(input logic [8:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [8:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = d;
    endtask

    // All operations start and end one time unit after a rising edge, with
    // req_valid dropped at the end, so consecutive calls stream back-to-back.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic op_word_store(input logic [8:0] a, input logic [31:0] d);
        drive(1'b1, 2'd2, 1'b0, a, d);
        @(negedge clk);
        check("ws_ready", 32'(req_ready), 32'd1);
        check("ws_write", 32'(mem_write), 32'd1);
        check("ws_read",  32'(mem_read),  32'd0);
        check("ws_addr",  32'(mem_address), 32'(a[8:2]));
        check("ws_wdata", mem_wdata, d);
        ref_store(a, 2'd2, d);
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic op_load(input logic [8:0] a, input logic [1:0] sz, input logic sgn,
                           output logic [31:0] got);
        int n;
        drive(1'b0, sz, sgn, a, $urandom);
        @(negedge clk);
        check("ld_ready", 32'(req_ready), 32'd1);
        check("ld_read",  32'(mem_read),  32'd1);
        check("ld_nowr",  32'(mem_write), 32'd0);
        check("ld_addr",  32'(mem_address), 32'(a[8:2]));
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("ld_wait_ready", 32'(req_ready), 32'd0);
        check("ld_wait_nomem", 32'({mem_read, mem_write}), 32'd0);
        check("ld_wait_valid", 32'(ld_valid), 32'd0);
        n = 1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            n = k + 2;
            if (ld_valid === 1'b1) break;
        end
        check("ld_latency", 32'(n), 32'd2);
        check("ld_valid",   32'(ld_valid), 32'd1);
        check("ld_data",    ld_data, ref_load(a, sz, sgn));
        check("ld_noerr",   32'(err), 32'd0);
        check("ld_ready_after", 32'(req_ready), 32'd1);
        got = ld_data;
        next_cycle();
    endtask

    task automatic op_sub_store(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] d,
                                output logic [31:0] wd);
        drive(1'b1, sz, 1'b0, a, d);
        @(negedge clk);
        check("rmw_ready", 32'(req_ready), 32'd1);
        check("rmw_read",  32'(mem_read),  32'd1);
        check("rmw_nowr",  32'(mem_write), 32'd0);
        check("rmw_addr",  32'(mem_address), 32'(a[8:2]));
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        ref_store(a, sz, d);
        check("rmw_busy",   32'(req_ready), 32'd0);
        check("rmw_write",  32'(mem_write), 32'd1);
        check("rmw_noread", 32'(mem_read),  32'd0);
        check("rmw_waddr",  32'(mem_address), 32'(a[8:2]));
        check("rmw_wdata",  mem_wdata, ref_word(a));
        wd = mem_wdata;
        next_cycle();
    endtask

    task automatic op_bad(input logic we, input logic [1:0] sz, input logic [8:0] a);
        drive(we, sz, 1'($urandom), a, $urandom);
        @(negedge clk);
        check("bad_ready",  32'(req_ready), 32'd1);
        check("bad_nomem0", 32'({mem_read, mem_write}), 32'd0);
        check("bad_err0",   32'(err), 32'd0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("bad_err",    32'(err), 32'd1);
        check("bad_idle",   32'(req_ready), 32'd1);
        check("bad_nomem1", 32'({mem_read, mem_write}), 32'd0);
        check("bad_nold",   32'(ld_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("bad_err_pulse", 32'(err), 32'd0);
        next_cycle();
    endtask

    logic [31:0] got;
    logic [8:0]  ra;
    logic [1:0]  rsz;
    logic        rwe;
    logic        rsg;
    logic [31:0] rd;

    initial begin
        // Reset with a request held on the bus: it must be ignored.
        drive(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_ready",  32'(req_ready), 32'd1);
        check("rst_ldv",    32'(ld_valid), 32'd0);
        check("rst_lddata", ld_data, 32'd0);
        check("rst_err",    32'(err), 32'd0);
        check("rst_mem",    32'({mem_read, mem_write}), 32'd0);
        check("rst_maddr",  32'(mem_address), 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Fill the whole memory with a back-to-back stream of word stores.
        for (int w = 0; w < 128; w++) op_word_store(9'(w * 4), $urandom);

        // Word store then signed/unsigned byte loads from the top lane.
        op_word_store(9'h010, 32'h80FF_7F01);
        op_load(9'h013, 2'd0, 1'b1, got);
        check("tp2_sbyte", got, 32'hFFFF_FF80);
        op_load(9'h013, 2'd0, 1'b0, got);
        check("tp2_ubyte", got, 32'h0000_0080);

        // Byte-store read-modify-write.
        op_word_store(9'h010, 32'h1122_3344);
        op_sub_store(9'h012, 2'd0, 32'hAB, got);
        check("tp3_merge", got, 32'h11AB_3344);

        // Halfword store and loads.
        op_word_store(9'h020, 32'h1234_5678);
        op_sub_store(9'h022, 2'd1, 32'hBEEF, got);
        check("tp4_merge", got, 32'hBEEF_5678);
        op_load(9'h022, 2'd1, 1'b1, got);
        check("tp4_shalf", got, 32'hFFFF_BEEF);
        op_load(9'h020, 2'd2, 1'b0, got);
        check("tp4_word", got, 32'hBEEF_5678);

        // Misaligned and reserved-size requests.
        op_bad(1'b1, 2'd1, 9'h001);
        op_bad(1'b0, 2'd2, 9'h006);
        op_bad(1'b0, 2'd3, 9'h000);

        // Four back-to-back word stores, then a load/RMW interleave.
        for (int i = 0; i < 4; i++) op_word_store(9'(9'h040 + 9'(i * 4)), $urandom);
        op_load(9'h044, 2'd2, 1'b0, got);
        op_sub_store(9'h049, 2'd0, $urandom, got);
        op_load(9'h049, 2'd0, 1'b1, got);
        op_sub_store(9'h04C, 2'd1, $urandom, got);
        op_load(9'h04C, 2'd1, 1'b0, got);

        // Reset during RMW_MERGE: the write must drop and memory stay intact.
        drive(1'b1, 2'd0, 1'b0, 9'h012, 32'h55);
        @(negedge clk);
        next_cycle();
        req_valid = 1'b0;
        #1;
        check("mrst_wr_before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_wr_drop", 32'({mem_read, mem_write}), 32'd0);
        check("mrst_ldv",     32'(ld_valid), 32'd0);
        check("mrst_ready",   32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        op_load(9'h010, 2'd2, 1'b0, got);
        check("mrst_mem_kept", got, 32'h11AB_3344);

        // Reset during LD_WAIT: the pending load never completes.
        drive(1'b0, 2'd2, 1'b0, 9'h020, 32'h0);
        @(negedge clk);
        next_cycle();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("lrst_lddata", ld_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check("lrst_no_ldv", 32'(ld_valid), 32'd0);
        end
        next_cycle();

        // Random traffic against the byte-array model.
        for (int i = 0; i < 80; i++) begin
            ra  = 9'($urandom);
            rsz = 2'($urandom);
            rwe = 1'($urandom);
            rsg = 1'($urandom);
            rd  = $urandom;
            if ($urandom_range(3) != 0) begin
                if (rsz == 2'd3) rsz = 2'($urandom_range(2));
                if (rsz == 2'd1) ra[0] = 1'b0;
                if (rsz == 2'd2) ra[1:0] = 2'b00;
            end
            if (is_misaligned(ra, rsz))      op_bad(rwe, rsz, ra);
            else if (!rwe)                   op_load(ra, rsz, rsg, got);
            else if (rsz == 2'd2)            op_word_store(ra, rd);
            else                             op_sub_store(ra, rsz, rd, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
